// File: rtl/lcd_pkg.sv
// Shared LCD image-memory definitions: FSM states, screen geometry and the RGB565 pixel type.
// Used by the rectangle writer, the block ROM/RAM reader and the scan-out logic.
package lcd_pkg;

    localparam int LCD_ADDR_WIDTH = 8;
    localparam int LCD_DATA_WIDTH = 16;
    localparam int LCD_LINE_WIDTH = 16;
    localparam int LCD_ROWS       = (2 ** LCD_ADDR_WIDTH) / LCD_LINE_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } lcd_state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic rgb565_t rgb565_pack(input logic [4:0] r, input logic [5:0] g,
                                            input logic [4:0] b);
        rgb565_t p;
        p.r = r;
        p.g = g;
        p.b = b;
        return p;
    endfunction

endpackage

// File: rtl/lcd_xy_scan.sv
// Raster x/y counter for the rectangle writer: loads the origin, steps across a row,
// reloads x at the row end and flags the final pixel of the clipped rectangle.
module lcd_xy_scan
    import lcd_pkg::*;
#(
    parameter int AW = LCD_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [AW-1:0] x0_i,
    input  logic [AW-1:0] y0_i,
    input  logic [AW-1:0] xr_i,
    input  logic [AW:0]   xe_i,
    input  logic [AW:0]   ye_i,
    output logic [AW-1:0] x_o,
    output logic [AW-1:0] y_o,
    output logic          row_end_o,
    output logic          last_o
);

    logic [AW-1:0] x_q, x_d;
    logic [AW-1:0] y_q, y_d;
    logic [AW:0]   x_inc;
    logic [AW:0]   y_inc;

    // Compare one bit wider than the coordinates so an end bound of LINE_WIDTH/ROWS fits.
    assign x_inc     = {1'b0, x_q} + (AW + 1)'(1);
    assign y_inc     = {1'b0, y_q} + (AW + 1)'(1);
    assign row_end_o = (x_inc == xe_i);
    assign last_o    = row_end_o && (y_inc == ye_i);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load_i) begin
            x_d = x0_i;
            y_d = y0_i;
        end else if (step_i) begin
            if (row_end_o) begin
                x_d = xr_i;
                y_d = y_inc[AW-1:0];
            end else begin
                x_d = x_inc[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/lcd_rect_writer.sv
// Rectangle-fill write engine: takes one clipped fill command and issues one image-RAM
// write per clock, then pulses done. All outputs come straight from registers.
module lcd_rect_writer
    import lcd_pkg::*;
#(
    parameter int ADDR_WIDTH = LCD_ADDR_WIDTH,
    parameter int DATA_WIDTH = LCD_DATA_WIDTH,
    parameter int LINE_WIDTH = LCD_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] x0,
    input  logic [ADDR_WIDTH-1:0] y0,
    input  logic [ADDR_WIDTH-1:0] w,
    input  logic [ADDR_WIDTH-1:0] h,
    input  logic [DATA_WIDTH-1:0] color,
    output logic                  busy,
    output logic                  done,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata
);

    localparam int ROWS = (2 ** ADDR_WIDTH) / LINE_WIDTH;
    localparam int XW   = $clog2(LINE_WIDTH);
    localparam logic [ADDR_WIDTH:0] LW_X   = (ADDR_WIDTH + 1)'(LINE_WIDTH);
    localparam logic [ADDR_WIDTH:0] ROWS_X = (ADDR_WIDTH + 1)'(ROWS);

    lcd_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] xr_q, xr_d;
    logic [ADDR_WIDTH:0]   xe_q, xe_d;
    logic [ADDR_WIDTH:0]   ye_q, ye_d;
    logic [DATA_WIDTH-1:0] color_q, color_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH:0]   sum_x, sum_y, xe_clip, ye_clip;
    logic                  empty_cmd;
    logic                  scan_load, scan_step;
    logic                  scan_row_end, scan_last;
    logic [ADDR_WIDTH-1:0] scan_x, scan_y;

    // Widened sums so x0+w cannot wrap before clipping to the screen edge.
    assign sum_x     = {1'b0, x0} + {1'b0, w};
    assign sum_y     = {1'b0, y0} + {1'b0, h};
    assign xe_clip   = (sum_x > LW_X)   ? LW_X   : sum_x;
    assign ye_clip   = (sum_y > ROWS_X) ? ROWS_X : sum_y;
    assign empty_cmd = (w == '0) || (h == '0) || ({1'b0, x0} >= LW_X) || ({1'b0, y0} >= ROWS_X);

    // Hold the scanner on the last pixel so waddr keeps the final address afterwards.
    assign scan_load = (state_q == ST_IDLE) && start && !empty_cmd;
    assign scan_step = we_q && !scan_last;

    lcd_xy_scan #(
        .AW(ADDR_WIDTH)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .load_i   (scan_load),
        .step_i   (scan_step),
        .x0_i     (x0),
        .y0_i     (y0),
        .xr_i     (xr_q),
        .xe_i     (xe_q),
        .ye_i     (ye_q),
        .x_o      (scan_x),
        .y_o      (scan_y),
        .row_end_o(scan_row_end),
        .last_o   (scan_last)
    );

    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        color_d = color_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    xr_d    = x0;
                    xe_d    = xe_clip;
                    ye_d    = ye_clip;
                    color_d = color;
                    busy_d  = 1'b1;
                    if (empty_cmd) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                        we_d    = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (scan_last) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    we_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            xr_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            color_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            color_q <= color_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // LINE_WIDTH is a power of two, so the row offset is a pure shift of the y register.
    assign waddr = (scan_y << XW) | scan_x;
    assign wdata = color_q;
    assign we    = we_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
